// File: rtl/pingpong_buf.sv
// ---------------------------------------------------------------------------
// pingpong_buf
//   Two-bank ping-pong buffer. The writer fills one bank at a time and
//   closes it on wlast or when the bank is full. Closed banks are handed to
//   the reader, which drains them in the same alternating order.
//
// Ports
//   clk       : single clock; all state updates on its rising edge
//   rst_n     : asynchronous active-low reset
//   wdata     : write data word
//   winc      : write request
//   wlast     : with winc, closes the current write bank after this word
//   wfull     : current write bank is still owned by the reader; writes refused
//   wovf      : sticky flag, set by a write request while wfull
//   rdata     : show-ahead read data from the current read bank
//   rvalid    : rdata holds a valid word
//   rready    : consumer accepts rdata this cycle
//   rlast     : current read word is the last of its bank
//   rempty    : inverse of rvalid
//   bank_rdy  : per-bank ready flags, bit i = bank i
// ---------------------------------------------------------------------------
module pingpong_buf #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                winc,
    input  logic                wlast,
    output logic                wfull,
    output logic                wovf,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rlast,
    output logic                rempty,
    output logic [1:0]          bank_rdy
);

    localparam int DEPTH = 1 << ADDRSIZE;

    // Storage: not reset
    logic [DATASIZE-1:0] r_mem [2][DEPTH];

    // Control state
    logic                r_wsel;
    logic [ADDRSIZE-1:0] r_waddr;
    logic                r_rsel;
    logic [ADDRSIZE-1:0] r_raddr;
    logic [1:0]          r_bank_rdy;
    logic [ADDRSIZE:0]   r_len0;
    logic [ADDRSIZE:0]   r_len1;
    logic                r_wovf;

    // Next-state
    logic                w_wsel_nxt;
    logic [ADDRSIZE-1:0] w_waddr_nxt;
    logic                w_rsel_nxt;
    logic [ADDRSIZE-1:0] w_raddr_nxt;
    logic [1:0]          w_bank_rdy_nxt;
    logic [ADDRSIZE:0]   w_len0_nxt;
    logic [ADDRSIZE:0]   w_len1_nxt;
    logic                w_wovf_nxt;

    // Decoded conditions
    logic                w_wfull;
    logic                w_wr_acc;
    logic                w_wr_close;
    logic [ADDRSIZE:0]   w_waddr_inc;
    logic                w_rvalid;
    logic [ADDRSIZE:0]   w_len_rsel;
    logic [ADDRSIZE:0]   w_raddr_inc;
    logic                w_rlast;
    logic                w_xfer;

    always_comb begin
        w_wfull     = r_bank_rdy[r_wsel];
        // rst_n gate keeps storage untouched while reset is held
        w_wr_acc    = rst_n && winc && !w_wfull;
        w_waddr_inc = {1'b0, r_waddr} + (ADDRSIZE+1)'(1);
        w_wr_close  = w_wr_acc && (wlast || (r_waddr == ADDRSIZE'(DEPTH - 1)));

        w_rvalid    = r_bank_rdy[r_rsel];
        w_len_rsel  = r_rsel ? r_len1 : r_len0;
        // Compare at ADDRSIZE+1 bits so a full bank (len = DEPTH) matches
        w_raddr_inc = {1'b0, r_raddr} + (ADDRSIZE+1)'(1);
        w_rlast     = w_rvalid && (w_raddr_inc == w_len_rsel);
        w_xfer      = w_rvalid && rready;
    end

    always_comb begin
        w_wsel_nxt     = r_wsel;
        w_waddr_nxt    = r_waddr;
        w_rsel_nxt     = r_rsel;
        w_raddr_nxt    = r_raddr;
        w_bank_rdy_nxt = r_bank_rdy;
        w_len0_nxt     = r_len0;
        w_len1_nxt     = r_len1;
        w_wovf_nxt     = r_wovf;

        if (winc && w_wfull) begin
            w_wovf_nxt = 1'b1;
        end

        if (w_wr_acc) begin
            if (w_wr_close) begin
                if (r_wsel) begin
                    w_len1_nxt = w_waddr_inc;
                end else begin
                    w_len0_nxt = w_waddr_inc;
                end
                w_bank_rdy_nxt[r_wsel] = 1'b1;
                w_wsel_nxt             = ~r_wsel;
                w_waddr_nxt            = '0;
            end else begin
                w_waddr_nxt = r_waddr + ADDRSIZE'(1);
            end
        end

        // Writer only targets a non-ready bank and reader only a ready one,
        // so the two bank_rdy updates never touch the same bit.
        if (w_xfer) begin
            if (w_rlast) begin
                w_bank_rdy_nxt[r_rsel] = 1'b0;
                w_rsel_nxt             = ~r_rsel;
                w_raddr_nxt            = '0;
            end else begin
                w_raddr_nxt = r_raddr + ADDRSIZE'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel     <= 1'b0;
            r_waddr    <= '0;
            r_rsel     <= 1'b0;
            r_raddr    <= '0;
            r_bank_rdy <= 2'b00;
            r_len0     <= '0;
            r_len1     <= '0;
            r_wovf     <= 1'b0;
        end else begin
            r_wsel     <= w_wsel_nxt;
            r_waddr    <= w_waddr_nxt;
            r_rsel     <= w_rsel_nxt;
            r_raddr    <= w_raddr_nxt;
            r_bank_rdy <= w_bank_rdy_nxt;
            r_len0     <= w_len0_nxt;
            r_len1     <= w_len1_nxt;
            r_wovf     <= w_wovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wsel][r_waddr] <= wdata;
        end
    end

    always_comb begin
        wfull    = w_wfull;
        wovf     = r_wovf;
        rdata    = r_mem[r_rsel][r_raddr];
        rvalid   = w_rvalid;
        rlast    = w_rlast;
        rempty   = !w_rvalid;
        bank_rdy = r_bank_rdy;
    end

endmodule

// File: tb/tb_pingpong_buf.sv
module tb_pingpong_buf;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] wdata;
    logic          winc;
    logic          wlast;
    logic          wfull;
    logic          wovf;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic          rempty;
    logic [1:0]    bank_rdy;

    pingpong_buf #(
        .DATASIZE(DW),
        .ADDRSIZE(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wdata    (wdata),
        .winc     (winc),
        .wlast    (wlast),
        .wfull    (wfull),
        .wovf     (wovf),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .rlast    (rlast),
        .rempty   (rempty),
        .bank_rdy (bank_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Closed blocks form a FIFO of words plus a FIFO of block lengths; the
    // writer's open block is a separate list. At most two blocks can be closed.
    logic [DW-1:0] m_words[$];
    int            m_len[$];
    logic [DW-1:0] m_part[$];
    int            m_ridx;
    int            m_rblocks;
    bit            m_ovf;

    function automatic bit m_rvalid();
        return m_len.size() > 0;
    endfunction

    function automatic bit m_rlast();
        if (m_len.size() == 0) return 1'b0;
        return (m_ridx + 1) == m_len[0];
    endfunction

    function automatic bit m_wfull();
        return m_len.size() == 2;
    endfunction

    function automatic logic [1:0] m_bank();
        logic [1:0] one;
        one = 2'b01;
        if (m_len.size() == 0) return 2'b00;
        if (m_len.size() == 2) return 2'b11;
        return one << (m_rblocks % 2);
    endfunction

    task automatic m_reset();
        m_words.delete();
        m_len.delete();
        m_part.delete();
        m_ridx    = 0;
        m_rblocks = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic m_step(input bit wi, input bit wl, input logic [DW-1:0] wd, input bit rr);
        bit full, rv, rl;
        full = m_wfull();
        rv   = m_rvalid();
        rl   = m_rlast();
        if (rr && rv) begin
            void'(m_words.pop_front());
            m_ridx++;
            if (rl) begin
                void'(m_len.pop_front());
                m_ridx = 0;
                m_rblocks++;
            end
        end
        if (wi && full) begin
            m_ovf = 1'b1;
        end else if (wi) begin
            m_part.push_back(wd);
            if (wl || m_part.size() == DEPTH) begin
                foreach (m_part[i]) m_words.push_back(m_part[i]);
                m_len.push_back(m_part.size());
                m_part.delete();
            end
        end
    endtask

    // Transfers observed on the read side
    logic [DW-1:0] got[$];
    bit            got_last[$];

    // One clock cycle: drive, compare pre-edge outputs to the model, clock.
    // Entered and left at posedge+1.
    task automatic cycle(input bit wi, input bit wl, input logic [DW-1:0] wd, input bit rr);
        winc  = wi;
        wlast = wl;
        wdata = wd;
        rready = rr;
        #1;
        chk("wfull", 32'(wfull), 32'(m_wfull()));
        chk("wovf", 32'(wovf), 32'(m_ovf));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid()));
        chk("rempty", 32'(rempty), 32'(!m_rvalid()));
        chk("rlast", 32'(rlast), 32'(m_rlast()));
        chk("bank_rdy", 32'(bank_rdy), 32'(m_bank()));
        if (m_rvalid()) chk("rdata", 32'(rdata), 32'(m_words[0]));
        if (rvalid && rready) begin
            got.push_back(rdata);
            got_last.push_back(rlast);
        end
        m_step(wi, wl, wd, rr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wfull"}, 32'(wfull), 32'd0);
        chk({tag, "_wovf"}, 32'(wovf), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_rlast"}, 32'(rlast), 32'd0);
        chk({tag, "_bank_rdy"}, 32'(bank_rdy), 32'd0);
    endtask

    task automatic do_reset();
        winc   = 1'b0;
        wlast  = 1'b0;
        wdata  = '0;
        rready = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_outputs("rst");
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          winc;
        logic          wlast;
        logic [DW-1:0] wdata;
        logic          rready;
        logic          e_wfull;
        logic          e_rvalid;
        logic          e_rlast;
        logic [DW-1:0] e_rdata;
        logic [1:0]    e_bank;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected outputs are those seen after the edge that applies each row
        tbl[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[1] = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[2] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 2'b01};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA2, 2'b01};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2'b01};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[6] = '{1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5C, 2'b10};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[8] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 2'b01};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};

        rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            winc   = tbl[i].winc;
            wlast  = tbl[i].wlast;
            wdata  = tbl[i].wdata;
            rready = tbl[i].rready;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wfull", i), 32'(wfull), 32'(tbl[i].e_wfull));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rvalid));
            chk($sformatf("vec%0d_rempty", i), 32'(rempty), 32'(!tbl[i].e_rvalid));
            chk($sformatf("vec%0d_rlast", i), 32'(rlast), 32'(tbl[i].e_rlast));
            chk($sformatf("vec%0d_bank_rdy", i), 32'(bank_rdy), 32'(tbl[i].e_bank));
            chk($sformatf("vec%0d_wovf", i), 32'(wovf), 32'd0);
            if (tbl[i].e_rvalid)
                chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].e_rdata));
        end

        // ---------------- fill both banks, overflow, drain ----------------
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        chk("fill0_bank_rdy", 32'(bank_rdy), 32'h1);
        chk("fill0_rvalid", 32'(rvalid), 32'h1);
        chk("fill0_rdata", 32'(rdata), 32'h00);
        for (int i = DEPTH; i < 2 * DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        chk("fill1_bank_rdy", 32'(bank_rdy), 32'h3);
        chk("fill1_wfull", 32'(wfull), 32'h1);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("ovf_wovf", 32'(wovf), 32'h1);
        chk("ovf_rdata", 32'(rdata), 32'h00);
        got.delete();
        got_last.delete();
        for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_count", 32'(got.size()), 32'(2 * DEPTH));
        for (int i = 0; i < got.size() && i < 2 * DEPTH; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(got[i]), 32'(i));
            chk($sformatf("drain_last%0d", i), 32'(got_last[i]),
                32'((i == DEPTH - 1) || (i == 2 * DEPTH - 1)));
        end
        chk("drain_rempty", 32'(rempty), 32'h1);

        // ---------------- reset mid-fill of bank 1 ----------------
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 3, DW'(8'h40 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(8'h50 + i), 1'b0);
        chk("pre_rst_bank_rdy", 32'(bank_rdy), 32'h1);
        #2;
        rst_n = 1'b0;
        winc  = 1'b1;
        wlast = 1'b1;
        wdata = 8'hBB;
        #1;
        chk_reset_outputs("async_rst");
        m_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_bank_rdy", 32'(bank_rdy), 32'h0);
        chk("rst_hold_wfull", 32'(wfull), 32'h0);
        #3;
        rst_n = 1'b1;
        winc  = 1'b0;
        wlast = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1, 8'h99, 1'b0);
        chk("post_rst_bank_rdy", 32'(bank_rdy), 32'h1);
        chk("post_rst_rdata", 32'(rdata), 32'h99);
        chk("post_rst_rlast", 32'(rlast), 32'h1);

        // ---------------- continuous streaming ----------------
        do_reset();
        got.delete();
        got_last.delete();
        for (int i = 0; i < 100; i++)
            cycle(1'b1, (i % 7 == 6) || (i == 99), DW'(8'h80 + i), 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream_count", 32'(got.size()), 32'd100);
        for (int i = 0; i < got.size() && i < 100; i++) begin
            chk($sformatf("stream_data%0d", i), 32'(got[i]), 32'(DW'(8'h80 + i)));
            chk($sformatf("stream_last%0d", i), 32'(got_last[i]),
                32'((i % 7 == 6) || (i == 99)));
        end
        chk("stream_wovf", 32'(wovf), 32'h0);
        chk("stream_rempty", 32'(rempty), 32'h1);

        // ---------------- randomized against the model ----------------
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            int rprob;
            rprob = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 500; i++) begin
                bit wi, wl, rr;
                wi = ($urandom_range(99) < 70);
                wl = ($urandom_range(99) < 15);
                rr = ($urandom_range(99) < rprob);
                cycle(wi, wl, DW'($urandom), rr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
